// File: rtl/rfnoc_pilot_qpsk_tx_if.sv
// AXI-Stream link used on both sides of the pilot/QPSK transmitter.
// The master drives data/last/valid and the slave drives ready.
interface rfnoc_pilot_qpsk_tx_if;
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tlast, tvalid, input tready);
    modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/rfnoc_pilot_qpsk_tx.sv
// QPSK transmitter: maps 16 two-bit symbols per input word to sc16 samples,
// with a BPSK PN pilot burst in front of every frame.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no frame in progress, waiting for input tvalid
// ST_PILOT   | emitting PILOT_LEN BPSK pilot samples from the PN LFSR
// ST_PAYLOAD | mapping buffered payload bits to QPSK samples
module rfnoc_pilot_qpsk_tx #(
    parameter int                 PILOT_LEN    = 64,
    parameter int                 PAYLOAD_SYMS = 256,
    parameter logic signed [15:0] AMP          = 16'sd11585
) (
    input  logic                         axis_data_clk,
    input  logic                         axis_data_rst,
    rfnoc_pilot_qpsk_tx_if.slave         s_in_axis,
    rfnoc_pilot_qpsk_tx_if.master        m_out_axis,
    output logic [31:0]                  frame_cnt
);
    localparam int          PIL_W = (PILOT_LEN > 1) ? $clog2(PILOT_LEN) : 1;
    localparam int          PAY_W = $clog2(PAYLOAD_SYMS);
    localparam logic [15:0] AMP_P = AMP;
    localparam logic [15:0] AMP_N = 16'(-AMP);
    localparam logic [6:0]  LFSR_SEED = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PILOT,
        ST_PAYLOAD
    } state_e;

    state_e             state_q, state_d;
    logic [6:0]         lfsr_q, lfsr_d;
    logic [PIL_W-1:0]   pil_cnt_q, pil_cnt_d;
    logic [PAY_W-1:0]   pay_cnt_q, pay_cnt_d;
    logic [31:0]        wreg_q, wreg_d;
    logic               wlast_q, wlast_d;
    logic               wv_q, wv_d;
    logic [3:0]         sidx_q, sidx_d;
    logic [31:0]        odata_q, odata_d;
    logic               olast_q, olast_d;
    logic               ovalid_q, ovalid_d;
    logic [31:0]        frame_cnt_q, frame_cnt_d;

    logic               adv;
    logic               in_rdy;
    logic               in_acc;
    logic               frame_end;
    logic [1:0]         sym;

    assign adv    = !ovalid_q || m_out_axis.tready;
    assign in_rdy = (state_q == ST_PAYLOAD) && (!wv_q || (adv && sidx_q == 4'd15));
    assign in_acc = in_rdy && s_in_axis.tvalid;
    assign sym    = wreg_q[{sidx_q, 1'b0} +: 2];
    assign frame_end = (sidx_q == 4'd15 && wlast_q) ||
                       (pay_cnt_q == PAY_W'(PAYLOAD_SYMS - 1));

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        pil_cnt_d   = pil_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        wreg_d      = wreg_q;
        wlast_d     = wlast_q;
        wv_d        = wv_q;
        sidx_d      = sidx_q;
        odata_d     = odata_q;
        olast_d     = olast_q;
        ovalid_d    = ovalid_q;
        frame_cnt_d = frame_cnt_q + 32'(ovalid_q && m_out_axis.tready && olast_q);

        // An emptied output slot goes invalid unless something is loaded below.
        if (adv) begin
            ovalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_in_axis.tvalid) begin
                    state_d   = ST_PILOT;
                    lfsr_d    = LFSR_SEED;
                    pil_cnt_d = '0;
                end
            end
            ST_PILOT: begin
                if (adv) begin
                    odata_d  = {lfsr_q[6] ? AMP_N : AMP_P, 16'h0000};
                    olast_d  = 1'b0;
                    ovalid_d = 1'b1;
                    lfsr_d   = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                    if (pil_cnt_q == PIL_W'(PILOT_LEN - 1)) begin
                        state_d   = ST_PAYLOAD;
                        pil_cnt_d = '0;
                    end else begin
                        pil_cnt_d = pil_cnt_q + PIL_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (adv && wv_q) begin
                    odata_d  = {sym[0] ? AMP_N : AMP_P, sym[1] ? AMP_N : AMP_P};
                    olast_d  = frame_end;
                    ovalid_d = 1'b1;
                    sidx_d   = sidx_q + 4'd1;
                    if (sidx_q == 4'd15) begin
                        wv_d = 1'b0;
                    end
                    if (frame_end) begin
                        pay_cnt_d = '0;
                        state_d   = s_in_axis.tvalid ? ST_PILOT : ST_IDLE;
                        lfsr_d    = LFSR_SEED;
                        pil_cnt_d = '0;
                    end else begin
                        pay_cnt_d = pay_cnt_q + PAY_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A word accepted on the last symbol refills the buffer seamlessly.
        if (in_acc) begin
            wreg_d  = s_in_axis.tdata;
            wlast_d = s_in_axis.tlast;
            wv_d    = 1'b1;
            sidx_d  = 4'd0;
        end
    end

    always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
        if (axis_data_rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LFSR_SEED;
            pil_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            wreg_q      <= '0;
            wlast_q     <= 1'b0;
            wv_q        <= 1'b0;
            sidx_q      <= 4'd0;
            odata_q     <= '0;
            olast_q     <= 1'b0;
            ovalid_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pil_cnt_q   <= pil_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            wreg_q      <= wreg_d;
            wlast_q     <= wlast_d;
            wv_q        <= wv_d;
            sidx_q      <= sidx_d;
            odata_q     <= odata_d;
            olast_q     <= olast_d;
            ovalid_q    <= ovalid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_in_axis.tready  = in_rdy;
    assign m_out_axis.tdata  = odata_q;
    assign m_out_axis.tlast  = olast_q;
    assign m_out_axis.tvalid = ovalid_q;
    assign frame_cnt         = frame_cnt_q;
endmodule

// File: tb/tb_rfnoc_pilot_qpsk_tx.sv
// Bench for the pilot/QPSK transmitter: directed scenarios with random payload,
// compared against a frame-level reference model of the sample stream.
module tb_rfnoc_pilot_qpsk_tx;
    localparam int          PILOT_LEN    = 64;
    localparam int          PAYLOAD_SYMS = 32;
    localparam logic [15:0] POS          = 16'h2D41;
    localparam logic [15:0] NEG          = 16'hD2BF;
    localparam int          TMO          = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] frame_cnt;

    rfnoc_pilot_qpsk_tx_if s_in ();
    rfnoc_pilot_qpsk_tx_if m_out ();

    rfnoc_pilot_qpsk_tx #(
        .PILOT_LEN   (PILOT_LEN),
        .PAYLOAD_SYMS(PAYLOAD_SYMS),
        .AMP         (16'sd11585)
    ) dut (
        .axis_data_clk(clk),
        .axis_data_rst(rst),
        .s_in_axis    (s_in),
        .m_out_axis   (m_out),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_t[$];
    logic [31:0] mw[$];
    logic        ml[$];
    logic [31:0] exp_d[$];
    logic        exp_l[$];

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: every frame is PILOT_LEN PN pilots followed by payload symbols
    // until an input-tlast word ends or PAYLOAD_SYMS symbols have been sent.
    function automatic void build_model();
        logic [6:0] lfsr;
        logic [1:0] b;
        logic       lst;
        int         pay = 0;
        bit         in_frame = 0;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < mw.size(); i++) begin
            for (int s = 0; s < 16; s++) begin
                if (!in_frame) begin
                    lfsr = 7'h7F;
                    for (int k = 0; k < PILOT_LEN; k++) begin
                        exp_d.push_back({lfsr[6] ? NEG : POS, 16'h0000});
                        exp_l.push_back(1'b0);
                        lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                    end
                    in_frame = 1;
                    pay = 0;
                end
                b   = 2'((mw[i] >> (2 * s)) & 32'h3);
                lst = (ml[i] && s == 15) || (pay == PAYLOAD_SYMS - 1);
                exp_d.push_back({b[0] ? NEG : POS, b[1] ? NEG : POS});
                exp_l.push_back(lst);
                pay++;
                if (lst) in_frame = 0;
            end
        end
    endfunction

    task automatic clear_q();
        got_d.delete(); got_l.delete(); got_t.delete();
        mw.delete(); ml.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_in.tvalid = 1'b0;
        s_in.tlast  = 1'b0;
        m_out.tready = 1'b1;
        repeat (3) @(posedge clk);
        clear_q();
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int t = 0;
        s_in.tdata  = d;
        s_in.tlast  = l;
        s_in.tvalid = 1'b1;
        @(negedge clk);
        while (!s_in.tready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("send_timeout", 33'(t < TMO), 33'd1);
        @(posedge clk); #1;
        s_in.tvalid = 1'b0;
        s_in.tlast  = 1'b0;
    endtask

    task automatic drain_and_compare(input string tag);
        int t = 0;
        int nf = 0;
        while (got_d.size() < exp_d.size() && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_timeout"}, 33'(t < TMO), 33'd1);
        repeat (4) @(negedge clk);
        check({tag, "_len"}, 33'(got_d.size()), 33'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
            check($sformatf("%s[%0d]", tag, i), {got_l[i], got_d[i]}, {exp_l[i], exp_d[i]});
        foreach (exp_l[i]) nf += int'(exp_l[i]);
        check({tag, "_frames"}, 33'(frame_cnt), 33'(nf));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] w;
        int          t;
        s_in.tdata   = '0;
        s_in.tlast   = 1'b0;
        s_in.tvalid  = 1'b0;
        m_out.tready = 1'b1;

        // Output monitor: records handshakes and checks AXIS hold / pilot-phase ready.
        fork
            begin
                int          frame_pos = 0;
                logic        prev_stall = 1'b0;
                logic [31:0] prev_d = '0;
                logic        prev_l = 1'b0;
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (rst) begin
                        frame_pos  = 0;
                        prev_stall = 1'b0;
                    end else begin
                        if (prev_stall) begin
                            check("stall_valid", 33'(m_out.tvalid), 33'd1);
                            check("stall_data", {m_out.tlast, m_out.tdata}, {prev_l, prev_d});
                        end
                        if (m_out.tvalid && frame_pos <= PILOT_LEN - 2)
                            check("pilot_in_ready", 33'(s_in.tready), 33'd0);
                        if (m_out.tvalid && m_out.tready) begin
                            got_d.push_back(m_out.tdata);
                            got_l.push_back(m_out.tlast);
                            got_t.push_back(cyc);
                            frame_pos = m_out.tlast ? 0 : frame_pos + 1;
                        end
                        prev_stall = m_out.tvalid && !m_out.tready;
                        prev_d     = m_out.tdata;
                        prev_l     = m_out.tlast;
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tvalid", 33'(m_out.tvalid), 33'd0);
        check("rst_tlast", 33'(m_out.tlast), 33'd0);
        check("rst_tdata", 33'(m_out.tdata), 33'd0);
        check("rst_in_ready", 33'(s_in.tready), 33'd0);
        check("rst_frame_cnt", 33'(frame_cnt), 33'd0);

        // T1: pilot sequence, first-pilot latency, throughput
        do_reset();
        w = $urandom();
        mw.push_back(w); ml.push_back(1'b1);
        build_model();
        fork
            send(w, 1'b1);
            begin
                @(negedge clk); check("t1_lat_a", 33'(m_out.tvalid), 33'd0);
                @(negedge clk); check("t1_lat_b", 33'(m_out.tvalid), 33'd0);
                @(negedge clk); check("t1_first", {m_out.tvalid, m_out.tdata}, {1'b1, NEG, 16'h0000});
            end
        join
        drain_and_compare("t1");
        if (got_d.size() >= PILOT_LEN + 16) begin
            check("t1_pilot7", 33'(got_d[7]), {1'b0, POS, 16'h0000});
            check("t1_pilot_rate", 33'(got_t[PILOT_LEN - 1] - got_t[0]), 33'(PILOT_LEN - 1));
            check("t1_payload_rate", 33'(got_t[PILOT_LEN + 15] - got_t[PILOT_LEN]), 33'd15);
        end

        // T2: mapping of 0xE4E4E4E4
        do_reset();
        mw.push_back(32'hE4E4E4E4); ml.push_back(1'b1);
        build_model();
        send(32'hE4E4E4E4, 1'b1);
        drain_and_compare("t2");
        if (got_d.size() >= PILOT_LEN + 4) begin
            check("t2_sym0", 33'(got_d[PILOT_LEN]), {1'b0, POS, POS});
            check("t2_sym1", 33'(got_d[PILOT_LEN + 1]), {1'b0, NEG, POS});
            check("t2_sym2", 33'(got_d[PILOT_LEN + 2]), {1'b0, POS, NEG});
            check("t2_sym3", 33'(got_d[PILOT_LEN + 3]), {1'b0, NEG, NEG});
        end

        // T3: frames cut at PAYLOAD_SYMS without input tlast
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mw.push_back($urandom()); ml.push_back(1'b0);
        end
        build_model();
        for (int i = 0; i < 4; i++) send(mw[i], ml[i]);
        drain_and_compare("t3");

        // T4: random backpressure, random input gaps and tlasts
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mw.push_back($urandom());
            ml.push_back((i == 7) || ($urandom_range(0, 3) == 0));
        end
        build_model();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(mw[i], ml[i]);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
            begin
                int g = 0;
                while (got_d.size() < exp_d.size() && g < 2 * TMO) begin
                    @(posedge clk); #1;
                    m_out.tready = 1'($urandom_range(0, 1));
                    g++;
                end
                m_out.tready = 1'b1;
            end
        join
        drain_and_compare("t4");

        // T5: reset at payload symbol 5, then a full fresh frame
        clear_q();
        w = $urandom();
        send(w, 1'b0);
        t = 0;
        while (got_d.size() < PILOT_LEN + 6 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("t5_reach_sym5", 33'(t < TMO), 33'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_tvalid_drop", 33'(m_out.tvalid), 33'd0);
        check("t5_frame_cnt", 33'(frame_cnt), 33'd0);
        repeat (2) @(posedge clk);
        clear_q();
        #1 rst = 1'b0;
        @(posedge clk); #1;
        w = $urandom();
        mw.push_back(w); ml.push_back(1'b1);
        build_model();
        send(w, 1'b1);
        drain_and_compare("t5");

        // T6: back-to-back frames, second word already waiting
        do_reset();
        for (int i = 0; i < 2; i++) begin
            mw.push_back($urandom()); ml.push_back(1'b1);
        end
        build_model();
        send(mw[0], 1'b1);
        send(mw[1], 1'b1);
        drain_and_compare("t6");
        if (got_d.size() >= 2 * (PILOT_LEN + 16)) begin
            check("t6_no_bubble", 33'(got_t[PILOT_LEN + 16] - got_t[PILOT_LEN + 15]), 33'd1);
            check("t6_payload_gap", 33'(got_t[2 * PILOT_LEN + 16] - got_t[2 * PILOT_LEN + 15]), 33'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
